id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register for the 5-stage RV32I core, directly upstream of the EX-stage forwarding unit.
//  - Latches decoded operands and control, and supplies EX_rs1/EX_rs2/EX_rd to forwarding.
//  - Detects load-use hazards: stalls IF/ID and inserts a bubble.
//  - Applies same-cycle WB write-through to the register-file read data.
//  - Handles branch flush and the external memory-busy hold.
// PARAMETERS
//  XLEN    32  datapath width
//  CTRL_W  16  width of opaque EX/MEM/WB control bundle passed through
// PORTS
//  CLK            in   1       clock, rising edge
//  RST            in   1       synchronous reset, active-high
//  hold           in   1       global freeze (data memory busy); register keeps contents
//  flush          in   1       branch/jump mispredict resolved in EX; kill instruction in ID
//  ID_valid       in   1       ID holds a real instruction
//  ID_pc          in   XLEN    PC of ID instruction
//  ID_rs1/ID_rs2  in   5       source register indices
//  ID_usesRs1/2   in   1       instruction actually reads rs1/rs2
//  ID_rd          in   5       destination index
//  ID_rs1_data    in   XLEN    regfile read port 1
//  ID_rs2_data    in   XLEN    regfile read port 2
//  ID_imm         in   XLEN    sign-extended immediate
//  ID_memRead     in   1       instruction is a load
//  ID_writeToReg  in   1       instruction writes rd
//  ID_ctrl        in   CTRL_W  remaining control bits
//  WB_rd          in   5       WB destination index
//  WB_data        in   XLEN    WB write data
//  WB_writeToReg  in   1       WB writes this cycle
//  stall          out  1       freeze PC and IF/ID (combinational)
//  EX_valid, EX_pc, EX_rs1, EX_rs2, EX_rd, EX_rs1_data, EX_rs2_data, EX_imm,
//  EX_memRead, EX_writeToReg, EX_ctrl
//                 out  as ID   registered copies
// BEHAVIOUR
//  - Reset: every EX_* output is 0; stall is 0 while RST=1.
//  - Latency: 1 cycle from ID_* to EX_*.
//  - Load-use detection, combinational:
//      lu = EX_valid & EX_memRead & EX_rd!=0 & ID_valid &
//           ((ID_usesRs1 & ID_rs1==EX_rd) | (ID_usesRs2 & ID_rs2==EX_rd))
//  - stall = lu & ~flush & ~hold & ~RST. hold freezes the core globally, so stall is not raised during hold.
//  - Next-state priority at posedge CLK:
//      1. RST: all EX_* <= 0.
//      2. hold: all EX_* keep their values. flush and lu are ignored this cycle.
//      3. flush: bubble.
//      4. lu: bubble.
//      5. Otherwise: load ID_*, with EX_valid <= ID_valid.
//  - Bubble: EX_valid, EX_memRead, EX_writeToReg and EX_rd <= 0, EX_ctrl <= 0; other fields don't-care (hold at 0).
//  - Invalid ID (ID_valid=0) loads with EX_writeToReg=0 and EX_memRead=0, so it can never forward or stall.
//  - Load-use stall lasts exactly 1 cycle: the bubble clears EX_memRead, so lu deasserts next cycle.
//  - WB write-through:
//      if WB_writeToReg & WB_rd!=0 & WB_rd==ID_rs1, latch WB_data into EX_rs1_data, else ID_rs1_data.
//      rs2 is handled identically. Applied only on normal load.
//  - x0: rd==0 never triggers lu or write-through.
// CONFIGURATION
//  IDEX_STALL_CNT_EN defined:
//    - Adds output stall_cnt [31:0].
//    - Increments on each posedge where a lu bubble is inserted (priority 4 taken).
//    - Saturates at 32'hFFFF_FFFF. Reset value 0. Frozen during hold.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  - Reset: RST=1 for 2 cycles with random ID_* -> all EX_*=0, stall=0.
//  - Load-use: EX holds lw x5 (EX_memRead=1, EX_rd=5); ID add x6,x5,x7 (usesRs1) ->
//      stall=1 that cycle, EX_valid=0 next cycle, stall=0 after, add enters EX one cycle later.
//  - No false stall:
//      - ID rs1=5 with ID_usesRs1=0 -> stall=0.
//      - EX_rd=0 load -> stall=0.
//      - EX non-load writing x5 -> stall=0.
//  - Write-through: WB_rd=3, WB_data=32'hDEADBEEF, WB_writeToReg=1; ID_rs2=3, ID_rs2_data=0 ->
//      EX_rs2_data=32'hDEADBEEF next cycle. Repeat with WB_rd=0 -> EX_rs2_data=0.
//  - Flush vs stall: lu condition true and flush=1 in the same cycle -> stall=0, EX_valid=0 next cycle.
//  - Hold: hold=1 for 3 cycles with EX_pc=32'h100 and changing ID_* ->
//      EX_* unchanged and stall=0 throughout; resumes normal load after hold drops.
//      With IDEX_STALL_CNT_EN, stall_cnt is also unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use detection, WB write-through, flush and hold.
// Optional IDEX_STALL_CNT_EN adds a saturating load-use bubble counter (stall_cnt).
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              hold,
  input  logic              flush,
  input  logic              ID_valid,
  input  logic [XLEN-1:0]   ID_pc,
  input  logic [4:0]        ID_rs1,
  input  logic [4:0]        ID_rs2,
  input  logic              ID_usesRs1,
  input  logic              ID_usesRs2,
  input  logic [4:0]        ID_rd,
  input  logic [XLEN-1:0]   ID_rs1_data,
  input  logic [XLEN-1:0]   ID_rs2_data,
  input  logic [XLEN-1:0]   ID_imm,
  input  logic              ID_memRead,
  input  logic              ID_writeToReg,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic [4:0]        WB_rd,
  input  logic [XLEN-1:0]   WB_data,
  input  logic              WB_writeToReg,
  output logic              stall,
  output logic              EX_valid,
  output logic [XLEN-1:0]   EX_pc,
  output logic [4:0]        EX_rs1,
  output logic [4:0]        EX_rs2,
  output logic [4:0]        EX_rd,
  output logic [XLEN-1:0]   EX_rs1_data,
  output logic [XLEN-1:0]   EX_rs2_data,
  output logic [XLEN-1:0]   EX_imm,
  output logic              EX_memRead,
  output logic              EX_writeToReg,
  output logic [CTRL_W-1:0] EX_ctrl
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic lu;
  logic hit1;
  logic hit2;
  logic wt1;
  logic wt2;

  assign hit1 = ID_usesRs1 & (ID_rs1 == EX_rd);
  assign hit2 = ID_usesRs2 & (ID_rs2 == EX_rd);

  assign lu = EX_valid & EX_memRead & (EX_rd != 5'd0)
            & ID_valid & (hit1 | hit2);

  assign stall = lu & ~flush & ~hold & ~RST;

  // Same-cycle regfile write is not yet visible on the read ports
  assign wt1 = WB_writeToReg & (WB_rd != 5'd0) & (WB_rd == ID_rs1);
  assign wt2 = WB_writeToReg & (WB_rd != 5'd0) & (WB_rd == ID_rs2);

  always_ff @(posedge CLK) begin
    if (RST || (!hold && (flush || lu))) begin
      EX_valid      <= 1'b0;
      EX_pc         <= '0;
      EX_rs1        <= '0;
      EX_rs2        <= '0;
      EX_rd         <= '0;
      EX_rs1_data   <= '0;
      EX_rs2_data   <= '0;
      EX_imm        <= '0;
      EX_memRead    <= 1'b0;
      EX_writeToReg <= 1'b0;
      EX_ctrl       <= '0;
    end else if (!hold) begin
      EX_valid      <= ID_valid;
      EX_pc         <= ID_pc;
      EX_rs1        <= ID_rs1;
      EX_rs2        <= ID_rs2;
      EX_rd         <= ID_rd;
      EX_rs1_data   <= wt1 ? WB_data : ID_rs1_data;
      EX_rs2_data   <= wt2 ? WB_data : ID_rs2_data;
      EX_imm        <= ID_imm;
      EX_memRead    <= ID_valid & ID_memRead;
      EX_writeToReg <= ID_valid & ID_writeToReg;
      EX_ctrl       <= ID_ctrl;
    end
  end

`ifdef IDEX_STALL_CNT_EN
  // stall is high exactly when a load-use bubble wins this edge
  always_ff @(posedge CLK) begin
    if (RST)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage.
// Optional IDEX_STALL_CNT_EN also checks stall_cnt.
module tb_id_ex_stage;

  logic        CLK;
  logic        RST;
  logic        hold;
  logic        flush;
  logic        ID_valid;
  logic [31:0] ID_pc;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_usesRs1;
  logic        ID_usesRs2;
  logic [4:0]  ID_rd;
  logic [31:0] ID_rs1_data;
  logic [31:0] ID_rs2_data;
  logic [31:0] ID_imm;
  logic        ID_memRead;
  logic        ID_writeToReg;
  logic [15:0] ID_ctrl;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data;
  logic        WB_writeToReg;
  logic        stall;
  logic        EX_valid;
  logic [31:0] EX_pc;
  logic [4:0]  EX_rs1;
  logic [4:0]  EX_rs2;
  logic [4:0]  EX_rd;
  logic [31:0] EX_rs1_data;
  logic [31:0] EX_rs2_data;
  logic [31:0] EX_imm;
  logic        EX_memRead;
  logic        EX_writeToReg;
  logic [15:0] EX_ctrl;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int          exp_cnt;
`endif

  int checks;
  int errors;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST), .hold(hold), .flush(flush),
    .ID_valid(ID_valid), .ID_pc(ID_pc),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_usesRs1(ID_usesRs1), .ID_usesRs2(ID_usesRs2),
    .ID_rd(ID_rd), .ID_rs1_data(ID_rs1_data),
    .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_memRead(ID_memRead), .ID_writeToReg(ID_writeToReg),
    .ID_ctrl(ID_ctrl), .WB_rd(WB_rd), .WB_data(WB_data),
    .WB_writeToReg(WB_writeToReg), .stall(stall),
    .EX_valid(EX_valid), .EX_pc(EX_pc),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data),
    .EX_imm(EX_imm), .EX_memRead(EX_memRead),
    .EX_writeToReg(EX_writeToReg), .EX_ctrl(EX_ctrl)
`ifdef IDEX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst, hold, flush, v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic [31:0] d1, d2;
    logic        mr, wr;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        wbw;
    logic        e_stall, e_v;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic [31:0] e_d1, e_d2;
    logic        e_mr, e_wr;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, hold, flush, v,
    input logic [31:0] pc,
    input logic [4:0] rs1, input logic u1,
    input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd,
    input logic [31:0] d1, d2,
    input logic mr, wr,
    input logic [4:0] wbrd, input logic [31:0] wbd,
    input logic wbw,
    input logic es, ev, input logic [31:0] epc,
    input logic [4:0] erd, input logic [31:0] ed1, ed2,
    input logic emr, ewr);
    vec_t t;
    t.rst = rst; t.hold = hold; t.flush = flush; t.v = v;
    t.pc = pc; t.rs1 = rs1; t.u1 = u1;
    t.rs2 = rs2; t.u2 = u2; t.rd = rd;
    t.d1 = d1; t.d2 = d2; t.mr = mr; t.wr = wr;
    t.wbrd = wbrd; t.wbd = wbd; t.wbw = wbw;
    t.e_stall = es; t.e_v = ev; t.e_pc = epc; t.e_rd = erd;
    t.e_d1 = ed1; t.e_d2 = ed2; t.e_mr = emr; t.e_wr = ewr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int idx);
    logic [31:0] eimm;
    logic [15:0] ectl;
    @(negedge CLK);
    RST = t.rst; hold = t.hold; flush = t.flush;
    ID_valid = t.v; ID_pc = t.pc;
    ID_rs1 = t.rs1; ID_usesRs1 = t.u1;
    ID_rs2 = t.rs2; ID_usesRs2 = t.u2;
    ID_rd = t.rd; ID_rs1_data = t.d1; ID_rs2_data = t.d2;
    ID_imm = ~t.pc; ID_ctrl = t.pc[15:0] ^ 16'h5A5A;
    ID_memRead = t.mr; ID_writeToReg = t.wr;
    WB_rd = t.wbrd; WB_data = t.wbd; WB_writeToReg = t.wbw;
    #1;
    chk($sformatf("stall[%0d]", idx), 32'(stall), 32'(t.e_stall));
    @(posedge CLK);
    #1;
    eimm = (t.e_pc == 32'd0) ? 32'd0 : ~t.e_pc;
    ectl = (t.e_pc == 32'd0) ? 16'd0 : (t.e_pc[15:0] ^ 16'h5A5A);
    chk($sformatf("valid[%0d]", idx), 32'(EX_valid), 32'(t.e_v));
    chk($sformatf("pc[%0d]", idx), EX_pc, t.e_pc);
    chk($sformatf("rd[%0d]", idx), 32'(EX_rd), 32'(t.e_rd));
    chk($sformatf("d1[%0d]", idx), EX_rs1_data, t.e_d1);
    chk($sformatf("d2[%0d]", idx), EX_rs2_data, t.e_d2);
    chk($sformatf("mr[%0d]", idx), 32'(EX_memRead), 32'(t.e_mr));
    chk($sformatf("wr[%0d]", idx), 32'(EX_writeToReg), 32'(t.e_wr));
    chk($sformatf("imm[%0d]", idx), EX_imm, eimm);
    chk($sformatf("ctrl[%0d]", idx), 32'(EX_ctrl), 32'(ectl));
`ifdef IDEX_STALL_CNT_EN
    if (t.rst) exp_cnt = 0;
    else if (t.e_stall) exp_cnt++;
    chk($sformatf("cnt[%0d]", idx), stall_cnt, 32'(exp_cnt));
`endif
  endtask

  vec_t vt[$];

  initial begin
    checks = 0;
    errors = 0;
`ifdef IDEX_STALL_CNT_EN
    exp_cnt = 0;
`endif
    RST = 1'b1; hold = 1'b0; flush = 1'b0;
    ID_valid = 1'b0; ID_pc = '0; ID_rs1 = '0; ID_rs2 = '0;
    ID_usesRs1 = 1'b0; ID_usesRs2 = 1'b0; ID_rd = '0;
    ID_rs1_data = '0; ID_rs2_data = '0; ID_imm = '0;
    ID_memRead = 1'b0; ID_writeToReg = 1'b0; ID_ctrl = '0;
    WB_rd = '0; WB_data = '0; WB_writeToReg = 1'b0;

    // reset with live-looking ID inputs
    vt.push_back(mk(1,0,0,1,'h40,5,1,5,1,5,'h1234,'h5678,1,1,5,'h9,1,
                    0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,1,'h40,5,1,5,1,5,'h1234,'h5678,1,1,5,'h9,1,
                    0,0,0,0,0,0,0,0));
    // lw x5 then add x6,x5,x7: one bubble then add
    vt.push_back(mk(0,0,0,1,'h10,2,1,0,0,5,'h1000,0,1,1,0,0,0,
                    0,1,'h10,5,'h1000,0,1,1));
    vt.push_back(mk(0,0,0,1,'h14,5,1,7,1,6,'h11,'h22,0,1,0,0,0,
                    1,0,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,'h14,5,1,7,1,6,'h11,'h22,0,1,0,0,0,
                    0,1,'h14,6,'h11,'h22,0,1));
    // rs1 matches but unused
    vt.push_back(mk(0,0,0,1,'h18,2,1,0,0,5,'h2000,0,1,1,0,0,0,
                    0,1,'h18,5,'h2000,0,1,1));
    vt.push_back(mk(0,0,0,1,'h1c,5,0,7,1,8,1,2,0,1,0,0,0,
                    0,1,'h1c,8,1,2,0,1));
    // load to x0
    vt.push_back(mk(0,0,0,1,'h20,2,1,0,0,0,'h30,0,1,1,0,0,0,
                    0,1,'h20,0,'h30,0,1,1));
    vt.push_back(mk(0,0,0,1,'h24,0,1,0,1,9,0,0,0,1,0,0,0,
                    0,1,'h24,9,0,0,0,1));
    // non-load writing x5
    vt.push_back(mk(0,0,0,1,'h28,1,1,0,0,5,5,0,0,1,0,0,0,
                    0,1,'h28,5,5,0,0,1));
    vt.push_back(mk(0,0,0,1,'h2c,5,1,0,0,10,7,0,0,1,0,0,0,
                    0,1,'h2c,10,7,0,0,1));
    // WB write-through on rs2, x0 guard, rs1, WB disabled
    vt.push_back(mk(0,0,0,1,'h30,4,1,3,1,11,4,0,0,1,3,'hDEADBEEF,1,
                    0,1,'h30,11,4,'hDEADBEEF,0,1));
    vt.push_back(mk(0,0,0,1,'h34,4,1,0,1,11,4,0,0,1,0,'hDEADBEEF,1,
                    0,1,'h34,11,4,0,0,1));
    vt.push_back(mk(0,0,0,1,'h38,4,1,0,0,12,0,0,0,1,4,'hCAFE0001,1,
                    0,1,'h38,12,'hCAFE0001,0,0,1));
    vt.push_back(mk(0,0,0,1,'h3c,4,1,0,0,12,'h99,0,0,1,4,'hCAFE0001,0,
                    0,1,'h3c,12,'h99,0,0,1));
    // flush beats load-use
    vt.push_back(mk(0,0,0,1,'h40,2,1,0,0,5,'h3000,0,1,1,0,0,0,
                    0,1,'h40,5,'h3000,0,1,1));
    vt.push_back(mk(0,0,1,1,'h44,5,1,7,1,6,'h11,'h22,0,1,0,0,0,
                    0,0,0,0,0,0,0,0));
    // invalid ID load clears memRead/writeToReg
    vt.push_back(mk(0,0,0,0,'h48,2,1,0,0,5,'h77,0,1,1,0,0,0,
                    0,0,'h48,5,'h77,0,0,0));
    vt.push_back(mk(0,0,0,1,'h4c,5,1,0,0,6,1,0,0,1,0,0,0,
                    0,1,'h4c,6,1,0,0,1));
    // reset masks stall
    vt.push_back(mk(0,0,0,1,'h50,2,1,0,0,5,'h4000,0,1,1,0,0,0,
                    0,1,'h50,5,'h4000,0,1,1));
    vt.push_back(mk(1,0,0,1,'h54,5,1,0,0,6,1,0,0,1,0,0,0,
                    0,0,0,0,0,0,0,0));

    foreach (vt[i]) run(vt[i], i);

    // hold: three frozen cycles with lu, flush and WB activity
    run(mk(0,0,0,1,'h100,2,1,0,0,5,'h5000,0,1,1,0,0,0,
           0,1,'h100,5,'h5000,0,1,1), 100);
    for (int k = 0; k < 3; k++)
      run(mk(0,1,(k == 1),1,32'h104 + 32'(4*k),5,1,7,1,
             5'(6+k),32'(k),32'(k+1),1,1,5,'hABCD0000,1,
             0,1,'h100,5,'h5000,0,1,1), 101 + k);
    run(mk(0,0,0,1,'h110,5,1,7,1,6,1,2,0,1,0,0,0,
           1,0,0,0,0,0,0,0), 104);
    run(mk(0,0,0,1,'h110,5,1,7,1,6,1,2,0,1,0,0,0,
           0,1,'h110,6,1,2,0,1), 105);
    chk("ex_rs1", 32'(EX_rs1), 32'd5);
    chk("ex_rs2", 32'(EX_rs2), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
